spi_instr_decoder: RTL

Sits directly downstream of the SPI bridge. It turns the byte stream (byte_sync / data_in) into register-file read and write strobes. It returns read data to the bridge on data_out so the bridge can shift it out on MISO. Each frame is two bytes: a command byte followed by a data byte.

---
 rtl/spi_instr_decoder.sv | 55 +++++
 1 files changed

// File: rtl/spi_instr_decoder.sv
// spi_instr_decoder: turns SPI bridge command/data byte pairs into register read/write strobes
module spi_instr_decoder #(
  parameter int ADDR_W      = 7,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_sync,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        data_write,
  input  logic [7:0]        data_read,
  output logic              busy,
  output logic              frame_err
);
  typedef enum logic {CMD, DATA} state_t;
  localparam int CW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic op_wr, expire;
  assign busy = state == DATA;
  always_comb begin
    expire  = state == DATA && !byte_sync && TIMEOUT_CYC != 0 && cnt == LAST;
    state_n = state == CMD ? (byte_sync ? DATA : CMD) : (byte_sync || expire ? CMD : DATA);
  end
  always_ff @(posedge clk) state <= rst ? CMD : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      addr       <= '0;
      data_write <= '0;
      frame_err  <= 1'b0;
      cnt        <= '0;
      op_wr      <= 1'b0;
    end else begin
      read      <= state == CMD && byte_sync && !data_in[7];
      write     <= state == DATA && byte_sync && op_wr;
      frame_err <= expire;
      cnt       <= state == DATA ? cnt + 1'b1 : '0;
      // read data is captured while the read strobe is up and dropped when the frame ends
      data_out  <= state_n == CMD ? 8'h00 : (read ? data_read : data_out);
      if (state == CMD && byte_sync) begin
        op_wr <= data_in[7];
        addr  <= ADDR_W'({data_in[5:0], data_in[6]});
      end
      if (state == DATA && byte_sync && op_wr) data_write <= data_in;
    end
  end
endmodule
